// File: rtl/frame_flusher_if.sv
// Pixel bus between the frame flusher, the glyph units it scans and the VGA adapter it writes.
// The master side drives the scan coordinates and the plot strobe. The slave side returns the glyph hit.
interface frame_flusher_if;
    logic [7:0] flush_x;
    logic [7:0] flush_y;
    logic       pix_enable;
    logic [5:0] pix_colour;
    logic [7:0] vga_x;
    logic [7:0] vga_y;
    logic [5:0] vga_colour;
    logic       vga_plot;

    modport master (
        output flush_x, flush_y, vga_x, vga_y, vga_colour, vga_plot,
        input  pix_enable, pix_colour
    );

    modport slave (
        input  flush_x, flush_y, vga_x, vga_y, vga_colour, vga_plot,
        output pix_enable, pix_colour
    );
endinterface

// File: rtl/frame_flusher.sv
// Sweeps every (x,y) of a WIDTH x HEIGHT frame and asks the glyph units for a colour at each point.
// It writes that colour to the VGA adapter one cycle later and pulses done once the whole frame is written.
//
// state | meaning
// IDLE  | waiting for start, scan coordinates parked at (0,0)
// SCAN  | presenting flush_x/flush_y, plotting the previous coordinate
// DRAIN | last pixel on vga_*, no further coordinates presented
// DONE  | one-cycle done pulse, rescan if continuous
module frame_flusher #(
    parameter int       WIDTH     = 160,
    parameter int       HEIGHT    = 120,
    parameter bit [5:0] BG_COLOUR = 6'b000000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   continuous,
    output logic                   busy,
    output logic                   done,
    frame_flusher_if.master        bus
);

    localparam logic [7:0] LAST_X = 8'(WIDTH - 1);
    localparam logic [7:0] LAST_Y = 8'(HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_next;
    logic   last_x, last_y;

    assign last_x = (bus.flush_x == LAST_X);
    assign last_y = (bus.flush_y == LAST_Y);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SCAN;
            SCAN:    if (last_x && last_y) state_next = DRAIN;
            DRAIN:   state_next = DONE;
            DONE:    state_next = continuous ? SCAN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            SCAN, DRAIN: busy = 1'b1;
            DONE:        done = 1'b1;
            default:     ;
        endcase
    end

    // Coordinates outside SCAN are held at (0,0) so any entry into SCAN starts at the origin.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.flush_x    <= '0;
            bus.flush_y    <= '0;
            bus.vga_x      <= '0;
            bus.vga_y      <= '0;
            bus.vga_colour <= '0;
            bus.vga_plot   <= 1'b0;
        end else if (state == SCAN) begin
            bus.vga_x      <= bus.flush_x;
            bus.vga_y      <= bus.flush_y;
            bus.vga_colour <= bus.pix_enable ? bus.pix_colour : BG_COLOUR;
            bus.vga_plot   <= 1'b1;
            if (last_x) begin
                bus.flush_x <= '0;
                bus.flush_y <= last_y ? 8'd0 : bus.flush_y + 8'd1;
            end else begin
                bus.flush_x <= bus.flush_x + 8'd1;
            end
        end else begin
            bus.flush_x  <= '0;
            bus.flush_y  <= '0;
            bus.vga_plot <= 1'b0;
        end
    end

endmodule

// File: tb/tb_frame_flusher.sv
// Directed bench for frame_flusher: a 4x3 frame instance and a 1x1 instance with a non-zero background.
// Each step checks the outputs against cycle positions counted from the start cycle.
module tb_frame_flusher;

    localparam int W = 4;
    localparam int H = 3;
    localparam int N = W * H;

    logic clk = 1'b0;
    logic reset;
    logic start_a, cont_a, busy_a, done_a;
    logic start_b, cont_b, busy_b, done_b;
    logic glyph_on;

    int vectors = 0;
    int miscompares = 0;

    frame_flusher_if bus_a ();
    frame_flusher_if bus_b ();

    assign bus_a.pix_enable = glyph_on && (bus_a.flush_x == 8'd2) && (bus_a.flush_y == 8'd1);
    assign bus_a.pix_colour = 6'h3F;
    assign bus_b.pix_enable = 1'b0;
    assign bus_b.pix_colour = 6'h15;

    frame_flusher #(.WIDTH(W), .HEIGHT(H), .BG_COLOUR(6'b000000)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .continuous(cont_a),
        .busy(busy_a), .done(done_a), .bus(bus_a)
    );

    frame_flusher #(.WIDTH(1), .HEIGHT(1), .BG_COLOUR(6'b101010)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .continuous(cont_b),
        .busy(busy_b), .done(done_b), .bus(bus_b)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " busy"}, 32'(busy_a), 32'd0);
        chk({tag, " done"}, 32'(done_a), 32'd0);
        chk({tag, " plot"}, 32'(bus_a.vga_plot), 32'd0);
        chk({tag, " flush"}, {16'd0, bus_a.flush_x, bus_a.flush_y}, 32'd0);
        chk({tag, " vga"}, {10'd0, bus_a.vga_x, bus_a.vga_y, bus_a.vga_colour}, 32'd0);
    endtask

    // Expected outputs rel cycles after the IDLE cycle that sampled start (4x3 frame).
    task automatic check_sweep(input string tag, input int rel);
        int k;
        logic [7:0] ex_fx, ex_fy;
        logic       ex_busy, ex_done, ex_plot;
        string      t;
        t = $sformatf("%s@%0d", tag, rel);
        ex_busy = (rel >= 1) && (rel <= N + 1);
        ex_done = (rel == N + 2);
        ex_plot = (rel >= 2) && (rel <= N + 1);
        ex_fx = 8'd0;
        ex_fy = 8'd0;
        if (rel >= 1 && rel <= N) begin
            k = rel - 1;
            ex_fx = 8'(k % W);
            ex_fy = 8'(k / W);
        end
        chk({t, " busy"}, 32'(busy_a), 32'(ex_busy));
        chk({t, " done"}, 32'(done_a), 32'(ex_done));
        chk({t, " plot"}, 32'(bus_a.vga_plot), 32'(ex_plot));
        chk({t, " flush_x"}, 32'(bus_a.flush_x), 32'(ex_fx));
        chk({t, " flush_y"}, 32'(bus_a.flush_y), 32'(ex_fy));
        if (ex_plot) begin
            k = rel - 2;
            chk({t, " vga_x"}, 32'(bus_a.vga_x), 32'(k % W));
            chk({t, " vga_y"}, 32'(bus_a.vga_y), 32'(k / W));
            chk({t, " vga_colour"}, 32'(bus_a.vga_colour),
                (glyph_on && (k % W) == 2 && (k / W) == 1) ? 32'h3F : 32'h00);
        end else if (rel >= N + 2) begin
            chk({t, " hold_x"}, 32'(bus_a.vga_x), 32'(W - 1));
            chk({t, " hold_y"}, 32'(bus_a.vga_y), 32'(H - 1));
            chk({t, " hold_colour"}, 32'(bus_a.vga_colour), 32'h00);
        end
    endtask

    initial begin
        reset = 1'b1;
        start_a = 1'b0; cont_a = 1'b0;
        start_b = 1'b0; cont_b = 1'b0;
        glyph_on = 1'b0;
        tick();
        tick();
        chk_all_zero("reset_a");
        chk("reset_b plot", 32'(bus_b.vga_plot), 32'd0);
        chk("reset_b busy_done", {30'd0, busy_b, done_b}, 32'd0);
        chk("reset_b vga", {10'd0, bus_b.vga_x, bus_b.vga_y, bus_b.vga_colour}, 32'd0);
        // start high while in reset must not launch a sweep
        start_a = 1'b1;
        tick();
        reset = 1'b0;
        start_a = 1'b0;
        chk_all_zero("reset_override");
        tick();

        // Plain sweep, background only
        check_sweep("plain", 0);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int rel = 1; rel <= N + 3; rel++) begin
            check_sweep("plain", rel);
            tick();
        end

        // Glyph hit at (2,1)
        glyph_on = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int rel = 1; rel <= N + 3; rel++) begin
            check_sweep("glyph", rel);
            tick();
        end
        glyph_on = 1'b0;

        // start re-pulsed mid-SCAN is ignored
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int rel = 1; rel <= N + 3; rel++) begin
            check_sweep("repulse", rel);
            start_a = (rel == 5);
            tick();
        end
        start_a = 1'b0;

        // Continuous: DONE goes straight back into SCAN
        cont_a = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int rel = 1; rel <= N + 2; rel++) begin
            check_sweep("cont1", rel);
            tick();
        end
        cont_a = 1'b0;
        for (int rel = 1; rel <= N + 3; rel++) begin
            check_sweep("cont2", rel);
            tick();
        end

        // Reset during SCAN at t0+6, restart at t0+10
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int rel = 1; rel <= 6; rel++) begin
            check_sweep("abort", rel);
            reset = (rel == 6);
            tick();
        end
        reset = 1'b0;
        for (int rel = 7; rel <= 10; rel++) begin
            chk_all_zero($sformatf("abort_idle@%0d", rel));
            start_a = (rel == 10);
            tick();
        end
        start_a = 1'b0;
        for (int rel = 1; rel <= N + 2; rel++) begin
            check_sweep("restart", rel);
            tick();
        end
        tick();

        // start held high through DONE: one IDLE cycle then a fresh sweep
        start_a = 1'b1;
        tick();
        for (int rel = 1; rel <= N + 3; rel++) begin
            check_sweep("held", rel);
            tick();
        end
        start_a = 1'b0;
        for (int rel = 1; rel <= N + 3; rel++) begin
            check_sweep("held2", rel);
            tick();
        end

        // 1x1 frame with non-zero background
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        chk("1x1@1 busy", 32'(busy_b), 32'd1);
        chk("1x1@1 plot", 32'(bus_b.vga_plot), 32'd0);
        chk("1x1@1 flush", {16'd0, bus_b.flush_x, bus_b.flush_y}, 32'd0);
        tick();
        chk("1x1@2 plot", 32'(bus_b.vga_plot), 32'd1);
        chk("1x1@2 busy_done", {30'd0, busy_b, done_b}, 32'b10);
        chk("1x1@2 vga", {10'd0, bus_b.vga_x, bus_b.vga_y, bus_b.vga_colour}, {10'd0, 16'd0, 6'b101010});
        tick();
        chk("1x1@3 busy_done", {30'd0, busy_b, done_b}, 32'b01);
        chk("1x1@3 plot", 32'(bus_b.vga_plot), 32'd0);
        chk("1x1@3 hold_colour", 32'(bus_b.vga_colour), 32'h2A);
        tick();
        chk("1x1@4 busy_done", {30'd0, busy_b, done_b}, 32'b00);
        chk("1x1@4 plot", 32'(bus_b.vga_plot), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/frame_flusher.md
FRAME_FLUSHER -- requirements
Module: frame_flusher

Interface
REQ-001: Parameter WIDTH, default 160, is the number of pixel columns per frame (1..256).
REQ-002: Parameter HEIGHT, default 120, is the number of pixel rows per frame (1..256).
REQ-003: Parameter BG_COLOUR, default 6'b000000, is the colour written where no glyph is enabled.
REQ-004: clk  input  1  single clock; all state changes on rising edge.
REQ-005: reset  input  1  synchronous, active-high reset.
REQ-006: start  input  1  request one frame sweep; sampled only in IDLE.
REQ-007: continuous  input  1  when high in DONE, begin the next sweep without returning to IDLE.
REQ-008: pix_enable  input  1  OR of all glyph-unit enables for the current flush_x/flush_y; combinational from flush_x/flush_y.
REQ-009: pix_colour  input  6  colour from the enabled glyph unit for the current flush_x/flush_y.
REQ-010: flush_x  output  8  current scan column driven to all glyph units; registered.
REQ-011: flush_y  output  8  current scan row driven to all glyph units; registered.
REQ-012: vga_x  output  8  column of the pixel being written to the VGA adapter; registered.
REQ-013: vga_y  output  8  row of the pixel being written; registered.
REQ-014: vga_colour  output  6  colour of the pixel being written; registered.
REQ-015: vga_plot  output  1  write strobe to the VGA adapter; registered.
REQ-016: busy  output  1  high in SCAN and DRAIN.
REQ-017: done  output  1  one-cycle pulse in DONE.

Function
REQ-018: The FSM SHALL have states IDLE, SCAN, DRAIN and DONE.
REQ-019: IDLE -> SCAN when start=1, with flush_x=0 and flush_y=0 loaded on that edge; otherwise IDLE holds and flush_x/flush_y stay 0.
REQ-020: In SCAN, each cycle flush_x SHALL increment; at WIDTH-1 flush_x wraps to 0 and flush_y increments.
REQ-021: When SCAN presents (WIDTH-1, HEIGHT-1), the next state SHALL be DRAIN and flush_x/flush_y SHALL return to 0.
REQ-022: In every SCAN cycle the following edge SHALL register vga_x=flush_x, vga_y=flush_y, vga_colour=(pix_enable ? pix_colour : BG_COLOUR) and vga_plot=1.
REQ-023: Latency from flush coordinate to vga output SHALL be exactly one cycle; pixel k in raster order (k=y*WIDTH+x) SHALL appear on vga_* with vga_plot=1 in cycle t0+2+k, where t0 is the IDLE cycle with start=1.
REQ-024: DRAIN SHALL last one cycle, during which the last pixel is on vga_*; next state DONE, with vga_plot cleared on that edge.
REQ-025: In DONE, done=1 and vga_plot=0; next state SCAN (flush reloaded to 0,0) if continuous=1, else IDLE.
REQ-026: done SHALL occur in cycle t0+WIDTH*HEIGHT+2; exactly WIDTH*HEIGHT plot strobes SHALL occur per sweep, none duplicated or skipped.
REQ-027: start asserted in any state other than IDLE SHALL be ignored; start held high through DONE with continuous=0 SHALL begin a new sweep from IDLE on the following cycle.
REQ-028: vga_x, vga_y and vga_colour SHALL hold their last values while vga_plot=0.
REQ-029: WIDTH=1 and/or HEIGHT=1 SHALL be handled: a 1x1 frame plots one pixel and finishes in 3 cycles after start.

Reset
REQ-030: reset=1 at a clock edge SHALL force IDLE and flush_x=flush_y=vga_x=vga_y=0, vga_colour=0, vga_plot=0, busy=0, done=0, overriding all other inputs.
REQ-031: reset asserted mid-SCAN or mid-DRAIN SHALL abort the sweep with no further vga_plot strobes; a new sweep requires start after reset is released.

Verification (WIDTH=4, HEIGHT=3 unless stated)
REQ-032: start pulse at t0, pix_enable=0 -> 12 strobes cycles t0+2..t0+13 in raster order (0,0),(1,0)..(3,2), all colour 6'b000000; done=1 only at t0+14; busy high t0+1..t0+13.
REQ-033: pix_enable=1 with pix_colour=6'b111111 only when flush=(2,1) -> only strobe for (2,1) at t0+8 carries 6'b111111.
REQ-034: continuous=1 held -> after done at t0+14, flush=(0,0) at t0+15 and pixel (0,0) strobed at t0+16; no IDLE cycle.
REQ-035: reset at t0+6 -> from t0+7 all outputs 0, state IDLE; start pulse at t0+10 -> full 12-pixel sweep from (0,0), done at t0+24.
REQ-036: start re-pulsed at t0+5 (mid-SCAN) -> no effect; sweep and done timing identical to REQ-032.
REQ-037: WIDTH=1, HEIGHT=1, start at t0 -> single strobe (0,0) at t0+2, done at t0+3, IDLE at t0+4.
